// File: rtl/small_calc_ctrl_if.sv
// ============================================================================
// Module : small_calc_ctrl_if
// Brief  : Command and datapath-control bundle for the small-calculator controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface small_calc_ctrl_if;
  logic       go;
  logic       clr;
  logic [1:0] op;
  logic       acc;
  logic [1:0] s1;
  logic [1:0] wa;
  logic       we;
  logic [1:0] raa;
  logic [1:0] rab;
  logic       rea;
  logic       reb;
  logic [1:0] c;
  logic       s2;
  logic       busy;
  logic       done;

  modport master (
    output go, clr, op, acc,
    input  s1, wa, we, raa, rab, rea, reb, c, s2, busy, done
  );

  modport slave (
    input  go, clr, op, acc,
    output s1, wa, we, raa, rab, rea, reb, c, s2, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/small_calc_ctrl.sv
// ============================================================================
// Module : small_calc_ctrl
// Brief  : Moore sequencer for the small-calculator datapath (load/exec/show).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module small_calc_ctrl #(
  parameter logic [1:0] RA = 2'd0,
  parameter logic [1:0] RB = 2'd1,
  parameter logic [1:0] RR = 2'd2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  small_calc_ctrl_if.slave cif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR0   = 4'd1,
    S_CLR1   = 4'd2,
    S_CLR2   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_EXEC   = 4'd6,
    S_DONE   = 4'd7,
    S_SHOW   = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic       r_acc;
  logic       r_res_valid;

  logic       w_rest;
  logic       w_take_clr;
  logic       w_take_go;
  logic       w_acc_go;

  // Commands are only honoured while resting; clr has priority over go.
  assign w_rest     = (r_state == S_IDLE) || (r_state == S_SHOW);
  assign w_take_clr = w_rest && cif.clr;
  assign w_take_go  = w_rest && !cif.clr && cif.go;
  assign w_acc_go   = w_take_go && cif.acc && r_res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_acc       <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take_go) begin
        r_op  <= cif.op;
        r_acc <= w_acc_go;
      end
      if (w_take_clr) begin
        r_res_valid <= 1'b0;
      end else if (r_state == S_EXEC) begin
        r_res_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_SHOW: begin
        if (w_take_clr)    w_next = S_CLR0;
        else if (w_acc_go) w_next = S_LOAD_B;
        else if (w_take_go) w_next = S_LOAD_A;
      end
      S_CLR0:   w_next = S_CLR1;
      S_CLR1:   w_next = S_CLR2;
      S_CLR2:   w_next = S_IDLE;
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_DONE;
      S_DONE:   w_next = S_SHOW;
      default:  w_next = S_IDLE;
    endcase
  end

  logic [1:0] w_s1;
  logic [1:0] w_wa;
  logic       w_we;
  logic [1:0] w_raa;
  logic [1:0] w_rab;
  logic       w_rea;
  logic       w_reb;
  logic [1:0] w_c;
  logic       w_s2;
  logic       w_busy;
  logic       w_done;

  always_comb begin
    w_s1   = 2'b00;
    w_wa   = 2'b00;
    w_we   = 1'b0;
    w_raa  = 2'b00;
    w_rab  = 2'b00;
    w_rea  = 1'b0;
    w_reb  = 1'b0;
    w_c    = 2'b00;
    w_s2   = 1'b1;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_CLR0, S_CLR1, S_CLR2: begin
        w_we   = 1'b1;
        w_s1   = 2'b10;
        w_busy = 1'b1;
        w_wa   = (r_state == S_CLR0) ? RA : ((r_state == S_CLR1) ? RB : RR);
      end
      S_LOAD_A: begin
        w_we   = 1'b1;
        w_s1   = 2'b00;
        w_wa   = RA;
        w_busy = 1'b1;
      end
      S_LOAD_B: begin
        w_we   = 1'b1;
        w_s1   = 2'b01;
        w_wa   = RB;
        w_busy = 1'b1;
      end
      S_EXEC: begin
        w_rea  = 1'b1;
        w_reb  = 1'b1;
        w_raa  = r_acc ? RR : RA;
        w_rab  = RB;
        w_c    = r_op;
        w_s1   = 2'b11;
        w_we   = 1'b1;
        w_wa   = RR;
        w_busy = 1'b1;
      end
      // Result is shown as R[RR] + 0: port B disabled reads zero.
      S_DONE, S_SHOW: begin
        w_rea  = 1'b1;
        w_raa  = RR;
        w_s2   = 1'b0;
        w_done = (r_state == S_DONE);
      end
      default: ;
    endcase
  end

  assign cif.s1   = w_s1;
  assign cif.wa   = w_wa;
  assign cif.we   = w_we;
  assign cif.raa  = w_raa;
  assign cif.rab  = w_rab;
  assign cif.rea  = w_rea;
  assign cif.reb  = w_reb;
  assign cif.c    = w_c;
  assign cif.s2   = w_s2;
  assign cif.busy = w_busy;
  assign cif.done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_small_calc_ctrl.sv
// ============================================================================
// Module : tb_small_calc_ctrl
// Brief  : Bench for small_calc_ctrl with a datapath model and a sequence-script reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_small_calc_ctrl;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  small_calc_ctrl_if cif();

  small_calc_ctrl #(.RA(2'd0), .RB(2'd1), .RR(2'd2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cif   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {s1,wa,we,raa,rab,rea,reb,c,s2,busy,done}
  typedef logic [15:0] vec_t;

  function automatic vec_t mk(input logic [1:0] s1, input logic [1:0] wa, input logic we,
                              input logic [1:0] raa, input logic [1:0] rab, input logic rea,
                              input logic reb, input logic [1:0] c, input logic s2,
                              input logic busy, input logic done);
    return {s1, wa, we, raa, rab, rea, reb, c, s2, busy, done};
  endfunction

  function automatic vec_t v_clr(input logic [1:0] a);
    return mk(2'd2, a, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic vec_t v_exec(input logic [1:0] o, input logic a);
    return mk(2'd3, 2'd2, 1'b1, a ? 2'd2 : 2'd0, 2'd1, 1'b1, 1'b1, o, 1'b1, 1'b1, 1'b0);
  endfunction

  vec_t V_IDLE, V_SHOW, V_DONE, V_LA, V_LB;
  initial begin
    V_IDLE = mk(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    V_SHOW = mk(2'd0, 2'd0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    V_DONE = mk(2'd0, 2'd0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    V_LA   = mk(2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    V_LB   = mk(2'd1, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
  end

  vec_t dut_vec;
  assign dut_vec = {cif.s1, cif.wa, cif.we, cif.raa, cif.rab, cif.rea, cif.reb,
                    cif.c, cif.s2, cif.busy, cif.done};

  // Reference: each accepted command queues its whole script of output phases.
  vec_t q[$];
  vec_t cur;
  vec_t rest;
  bit   m_valid;
  bit   m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur     = V_IDLE;
      rest    = V_IDLE;
      m_valid = 1'b0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur == rest) begin
      if (cif.clr) begin
        cur = v_clr(2'd0);
        q.push_back(v_clr(2'd1));
        q.push_back(v_clr(2'd2));
        rest    = V_IDLE;
        m_valid = 1'b0;
      end else if (cif.go) begin
        m_acc = cif.acc && m_valid;
        if (m_acc) begin
          cur = V_LB;
        end else begin
          cur = V_LA;
          q.push_back(V_LB);
        end
        q.push_back(v_exec(cif.op, m_acc));
        q.push_back(V_DONE);
        rest    = V_SHOW;
        m_valid = 1'b1;
      end
    end else begin
      cur = rest;
    end
  end

  always @(negedge clk) begin
    total++;
    if (dut_vec !== cur) begin
      bad++;
      $display("FAIL ctrl_vec t=%0t actual=%h required=%h", $time, dut_vec, cur);
    end
  end

  // Datapath plant driven by the controller outputs.
  logic [3:0] in1, in2;
  logic [3:0] rf [4];
  logic [3:0] rd_a, rd_b, alu, dp_out, wdata;

  always_comb begin
    rd_a = cif.rea ? rf[cif.raa] : 4'd0;
    rd_b = cif.reb ? rf[cif.rab] : 4'd0;
    case (cif.c)
      2'd0:    alu = rd_a + rd_b;
      2'd1:    alu = rd_a - rd_b;
      2'd2:    alu = rd_a & rd_b;
      default: alu = rd_a | rd_b;
    endcase
    dp_out = cif.s2 ? 4'd0 : alu;
    case (cif.s1)
      2'd0:    wdata = in1;
      2'd1:    wdata = in2;
      2'd2:    wdata = 4'd0;
      default: wdata = alu;
    endcase
  end

  always @(posedge clk) begin
    if (cif.we) rf[cif.wa] <= wdata;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #1;
      if (cif.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] o, input logic ac, input int lat, input int res);
    int n;
    in1 = a; in2 = b; cif.op = o; cif.acc = ac; cif.go = 1'b1;
    tick();
    cif.go = 1'b0; cif.acc = 1'b0;
    wait_done(n);
    check({name, "_lat"}, n, lat);
    check({name, "_out"}, dp_out, res);
    tick();
    check({name, "_show"}, dp_out, res);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) rf[i] = 4'd0;
    rst_n = 1'b0; cif.go = 1'b0; cif.clr = 1'b0; cif.op = 2'd0; cif.acc = 1'b0;
    in1 = 4'd0; in2 = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", cif.busy, 0);
    check("rst_s2", cif.s2, 1);
    check("rst_done", cif.done, 0);
    rst_n = 1'b1;
    tick();

    run_op("add", 4'd3, 4'd4, 2'd0, 1'b0, 4, 7);
    run_op("sub", 4'd2, 4'd5, 2'd1, 1'b0, 4, 13);
    run_op("add2", 4'd3, 4'd4, 2'd0, 1'b0, 4, 7);
    run_op("acc1", 4'd0, 4'd1, 2'd0, 1'b1, 3, 8);
    run_op("acc2", 4'd0, 4'd1, 2'd0, 1'b1, 3, 9);
    run_op("acc3", 4'd0, 4'd1, 2'd0, 1'b1, 3, 10);

    cif.clr = 1'b1; cif.go = 1'b1;
    tick();
    cif.clr = 1'b0; cif.go = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #1;
      if (!cif.busy) begin
        n = i;
        break;
      end
    end
    check("clr_len", n, 4);
    check("clr_out", dp_out, 0);
    check("clr_ra", rf[0], 0);
    check("clr_rb", rf[1], 0);
    check("clr_rr", rf[2], 0);
    tick();
    run_op("acc_after_clr", 4'd6, 4'd2, 2'd0, 1'b1, 4, 8);

    in1 = 4'd1; in2 = 4'd1; cif.op = 2'd0; cif.go = 1'b1;
    tick();
    cif.go = 1'b0;
    tick();
    cif.go = 1'b1;
    tick();
    tick();
    cif.go = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (cif.done) n++;
    end
    check("ign_go_done_cnt", n, 1);
    check("ign_go_out", dp_out, 2);

    in1 = 4'd5; in2 = 4'd5; cif.go = 1'b1;
    tick();
    cif.go = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", cif.busy, 0);
    check("rst_mid_we", cif.we, 0);
    check("rst_mid_s2", cif.s2, 1);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (cif.done) n++;
    end
    check("rst_mid_nodone", n, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    run_op("acc_after_rst", 4'd9, 4'd9, 2'd0, 1'b1, 4, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/small_calc_ctrl.md
Name: small_calc_ctrl

Overview:
- Moore control unit that sequences the small-calculator datapath (input mux, 4x4 register file, ALU, output mux) through load, execute and display phases.
- Supports a single operation, an accumulate mode that chains onto the previous result, and a register-clear sequence.
- Sits beside the datapath; every datapath select, address and enable comes from this block.

Parameters:
- RA, 2'd0, register-file address of operand A.
- RB, 2'd1, register-file address of operand B.
- RR, 2'd2, register-file address of the result.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  start request, sampled in IDLE/SHOW.
- clr  in  1  clear request, sampled in IDLE/SHOW.
- op  in  2  ALU operation code, passed unchanged to c.
- acc  in  1  accumulate: use the previous result as operand A.
- s1  out  2  input-mux select: 00 in1, 01 in2, 10 zero, 11 aluout.
- wa  out  2  register-file write address.
- we  out  1  register-file write enable.
- raa  out  2  read address, port A.
- rab  out  2  read address, port B.
- rea  out  1  read enable, port A.
- reb  out  1  read enable, port B.
- c  out  2  ALU operation.
- s2  out  1  output-mux select: 0 aluout, 1 forced zero.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset: state=IDLE, op_q=00, acc_q=0, res_valid=0. Outputs follow the IDLE decode: s1=00, wa=00, we=0, raa=00, rab=00, rea=0, reb=0, c=00, s2=1, busy=0, done=0.
- Outputs decode from the state register only. op_q and acc_q are captured on the edge that accepts go.
- A disabled read port drives 0000 (register-file rule). The result is displayed as R[RR] + 0 with c=00 (ADD).
- States and outputs (unlisted outputs take their IDLE value):
  - IDLE: idle, out forced to zero.
  - CLR0/CLR1/CLR2: we=1, s1=10, wa=RA/RB/RR respectively, busy=1.
  - LOAD_A: we=1, s1=00, wa=RA, busy=1.
  - LOAD_B: we=1, s1=01, wa=RB, busy=1.
  - EXEC: rea=1, reb=1, rab=RB, c=op_q, s1=11, we=1, wa=RR, busy=1. raa=RR if acc_q else RA.
  - DONE: rea=1, raa=RR, reb=0, c=00, s2=0, done=1.
  - SHOW: same as DONE but done=0. Holds the result on out indefinitely.
- Transitions:
  - IDLE/SHOW: clr → CLR0 (clr beats go). Else go with acc=1 and res_valid=1 → LOAD_B. Else go → LOAD_A. Otherwise stay.
  - CLR0→CLR1→CLR2→IDLE. res_valid is cleared on entry to CLR0.
  - LOAD_A→LOAD_B→EXEC→DONE→SHOW. res_valid is set on the EXEC→DONE edge.
- Latency from the go-accepting edge: normal op, done high 4 cycles later (LOAD_A, LOAD_B, EXEC, DONE); accumulate, 3 cycles later.
- acc=1 with res_valid=0 (after reset or clear) runs the normal 4-cycle sequence, and acc_q is captured as 0.
- go and clr are ignored while busy=1 or in DONE. Holding go continuously restarts on every SHOW cycle.
- ALU arithmetic is 4-bit modulo-16. The controller performs no overflow detection.
- rst_n low mid-sequence: immediate return to IDLE, partial writes are abandoned, res_valid=0.

Test Plan:
- Reset, then in1=3, in2=4, op=00 (ADD), pulse go → busy 3 cycles, done pulse on the 4th cycle, out=4'd7 from DONE onward, held in SHOW.
- Then in1=2, in2=5, op=01 (SUB) → out=4'b1101 (wrap-around), 4-cycle latency.
- From SHOW with result 7, in2=1, op=00, acc=1 → LOAD_A skipped, raa=RR in EXEC, out=4'd8 after 3 cycles; repeating go gives 9, 10.
- clr and go asserted together in SHOW → CLR0..CLR2 write zero to RA/RB/RR, IDLE, out=0. A following acc=1 go runs the full 4-cycle sequence.
- go pulsed during LOAD_B and EXEC → ignored, exactly one done pulse. rst_n low during EXEC → outputs return to IDLE values at once, no done.
